// File: rtl/io_port_bank.sv
// io_port_bank: parametrised memory-mapped I/O register bank.
// Each port is a CPU-written output register, a sampled hardware input, or a
// sticky (OR-accumulating, clear-on-read) hardware input. Accesses produce
// one-cycle write/read strobes. Reads return data one cycle later with rd_valid.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   adrs, wr_data     access address and write data
//   we, re            write / read request (write wins when both are set)
//   rd_data, rd_valid registered read data and its one-cycle qualifier
//   port_out          output port registers, port i at [i*DATA_W +: DATA_W]
//   port_in           peripheral inputs, same packing
//   wr_strobe         one-cycle pulse per written port
//   rd_strobe         one-cycle pulse per read port
module io_port_bank #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 4,
    parameter int unsigned       NPORTS      = 16,
    parameter logic [NPORTS-1:0] IN_MASK     = '0,
    parameter logic [NPORTS-1:0] STICKY_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        adrs,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     we,
    input  logic                     re,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [NPORTS*DATA_W-1:0] port_out,
    input  logic [NPORTS*DATA_W-1:0] port_in,
    output logic [NPORTS-1:0]        wr_strobe,
    output logic [NPORTS-1:0]        rd_strobe
);

    // One register per port: written value for outputs, sampled value for inputs.
    logic [DATA_W-1:0] regs_q [NPORTS];
    logic [DATA_W-1:0] regs_d [NPORTS];

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [NPORTS-1:0] wr_strobe_q, wr_strobe_d;
    logic [NPORTS-1:0] rd_strobe_q, rd_strobe_d;

    logic [NPORTS-1:0] sel_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic [DATA_W-1:0] rd_mux_c;

    // Address decode; out-of-range addresses select nothing.
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < NPORTS; i++) begin
            sel_c[i] = (32'(adrs) == 32'(i));
        end
    end

    // A write takes priority; a read is accepted only without a same-cycle write.
    assign wr_acc_c = we;
    assign rd_acc_c = re && !we;

    // Read mux over current register values; zero when no port is selected.
    always_comb begin
        rd_mux_c = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel_c[i]) begin
                rd_mux_c = regs_q[i];
            end
        end
    end

    // Per-port next state.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            regs_d[i] = regs_q[i];
            if (IN_MASK[i]) begin
                if (STICKY_MASK[i]) begin
                    // New set bits win over a same-cycle read clear.
                    regs_d[i] = ((rd_acc_c && sel_c[i]) ? '0 : regs_q[i])
                              | port_in[i*DATA_W +: DATA_W];
                end else begin
                    regs_d[i] = port_in[i*DATA_W +: DATA_W];
                end
            end else if (wr_acc_c && sel_c[i]) begin
                regs_d[i] = wr_data;
            end
        end
    end

    // Read result, qualifier and strobes for the following cycle.
    always_comb begin
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_acc_c;
        wr_strobe_d = '0;
        rd_strobe_d = '0;
        if (rd_acc_c) begin
            rd_data_d   = rd_mux_c;
            rd_strobe_d = sel_c;
        end
        if (wr_acc_c) begin
            wr_strobe_d = sel_c;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPORTS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_strobe_q <= '0;
            rd_strobe_q <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    // Output ports expose their register; input-port slices drive zero.
    always_comb begin
        port_out = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!IN_MASK[i]) begin
                port_out[i*DATA_W +: DATA_W] = regs_q[i];
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_strobe = wr_strobe_q;
    assign rd_strobe = rd_strobe_q;

endmodule
